// File: rtl/guess_entry_if.sv
// Player-side signal bundle for guess_entry: round control and raw inputs in,
// latched guess, guess count and result flags out.
`timescale 1ns/1ps
interface guess_entry_if;
  logic [3:0] SecretVal;
  logic       new_round;
  logic [3:0] GuessSwitches;
  logic       SubmitButton;
  logic [3:0] SystemValAtGuess;
  logic [3:0] GuessNum;
  logic       guess_valid;
  logic       too_high;
  logic       too_low;
  logic       correct;
  logic       round_over;

  modport master (
    output SecretVal, new_round, GuessSwitches, SubmitButton,
    input  SystemValAtGuess, GuessNum, guess_valid, too_high, too_low, correct, round_over
  );

  modport slave (
    input  SecretVal, new_round, GuessSwitches, SubmitButton,
    output SystemValAtGuess, GuessNum, guess_valid, too_high, too_low, correct, round_over
  );
endinterface

// File: rtl/guess_entry.sv
// Guess entry front end: synchronises and debounces the submit button, then
// scores each accepted guess against the round's secret and tracks win/loss.
`timescale 1ns/1ps
module guess_entry #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned MAX_GUESSES     = 15
) (
  input logic          clock_100Mhz,
  input logic          reset,
  guess_entry_if.slave io
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]    MAX_G  = 4'(MAX_GUESSES);

  typedef enum logic [1:0] {IDLE, PLAY, WON, LOST} state_e;

  state_e          state_q, state_d;
  logic            btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d;
  logic [3:0]      sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
  logic            btn_stable_q, btn_stable_d, btn_prev_q, btn_prev_d;
  logic [CW-1:0]   db_cnt_q, db_cnt_d;
  logic [3:0]      secret_q, secret_d;
  logic [3:0]      val_q, val_d, num_q, num_d;
  logic            guess_valid_q, guess_valid_d;
  logic            too_high_q, too_high_d, too_low_q, too_low_d, correct_q, correct_d;
  logic            round_over_q, round_over_d;
  logic            press;
  logic [3:0]      num_inc;

  always_comb begin
    btn_s1_d      = io.SubmitButton;
    btn_s2_d      = btn_s1_q;
    sw_s1_d       = io.GuessSwitches;
    sw_s2_d       = sw_s1_q;
    btn_prev_d    = btn_stable_q;
    btn_stable_d  = btn_stable_q;
    db_cnt_d      = db_cnt_q;
    state_d       = state_q;
    secret_d      = secret_q;
    val_d         = val_q;
    num_d         = num_q;
    guess_valid_d = 1'b0;
    too_high_d    = too_high_q;
    too_low_d     = too_low_q;
    correct_d     = correct_q;
    num_inc       = num_q + 4'd1;
    press         = btn_stable_q & ~btn_prev_q;

    // Any cycle of agreement restarts the stability count.
    if (btn_s2_q == btn_stable_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_MAX) begin
      btn_stable_d = btn_s2_q;
      db_cnt_d     = '0;
    end else begin
      db_cnt_d = db_cnt_q + 1'b1;
    end

    if (io.new_round) begin
      secret_d   = io.SecretVal;
      val_d      = '0;
      num_d      = '0;
      too_high_d = 1'b0;
      too_low_d  = 1'b0;
      correct_d  = 1'b0;
      state_d    = PLAY;
    end else if (press && (state_q == PLAY)) begin
      val_d         = sw_s2_q;
      num_d         = num_inc;
      guess_valid_d = 1'b1;
      too_high_d    = (sw_s2_q > secret_q);
      too_low_d     = (sw_s2_q < secret_q);
      correct_d     = (sw_s2_q == secret_q);
      // A correct final guess takes priority over running out of guesses.
      if (sw_s2_q == secret_q) begin
        state_d = WON;
      end else if (num_inc == MAX_G) begin
        state_d = LOST;
      end
    end

    round_over_d = (state_d == WON) || (state_d == LOST);
  end

  always_ff @(posedge clock_100Mhz or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      btn_s1_q      <= 1'b0;
      btn_s2_q      <= 1'b0;
      sw_s1_q       <= '0;
      sw_s2_q       <= '0;
      btn_stable_q  <= 1'b0;
      btn_prev_q    <= 1'b0;
      db_cnt_q      <= '0;
      secret_q      <= '0;
      val_q         <= '0;
      num_q         <= '0;
      guess_valid_q <= 1'b0;
      too_high_q    <= 1'b0;
      too_low_q     <= 1'b0;
      correct_q     <= 1'b0;
      round_over_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      btn_s1_q      <= btn_s1_d;
      btn_s2_q      <= btn_s2_d;
      sw_s1_q       <= sw_s1_d;
      sw_s2_q       <= sw_s2_d;
      btn_stable_q  <= btn_stable_d;
      btn_prev_q    <= btn_prev_d;
      db_cnt_q      <= db_cnt_d;
      secret_q      <= secret_d;
      val_q         <= val_d;
      num_q         <= num_d;
      guess_valid_q <= guess_valid_d;
      too_high_q    <= too_high_d;
      too_low_q     <= too_low_d;
      correct_q     <= correct_d;
      round_over_q  <= round_over_d;
    end
  end

  assign io.SystemValAtGuess = val_q;
  assign io.GuessNum         = num_q;
  assign io.guess_valid      = guess_valid_q;
  assign io.too_high         = too_high_q;
  assign io.too_low          = too_low_q;
  assign io.correct          = correct_q;
  assign io.round_over       = round_over_q;

endmodule

// File: tb/tb_guess_entry.sv
// Bench for guess_entry: two instances (15 and 2 guesses per round) driven by
// shared stimulus and compared every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_guess_entry;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] secret = '0;
  logic       nr = 1'b0;
  logic [3:0] sw = '0;
  logic       btn = 1'b0;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  guess_entry_if if_a ();
  guess_entry_if if_b ();

  assign if_a.SecretVal = secret;
  assign if_a.new_round = nr;
  assign if_a.GuessSwitches = sw;
  assign if_a.SubmitButton = btn;
  assign if_b.SecretVal = secret;
  assign if_b.new_round = nr;
  assign if_b.GuessSwitches = sw;
  assign if_b.SubmitButton = btn;

  guess_entry #(.DEBOUNCE_CYCLES(D), .MAX_GUESSES(15)) dut_a (
    .clock_100Mhz(clk), .reset(rst_n), .io(if_a)
  );
  guess_entry #(.DEBOUNCE_CYCLES(D), .MAX_GUESSES(2)) dut_b (
    .clock_100Mhz(clk), .reset(rst_n), .io(if_b)
  );

  // Behavioural model: the button is accepted once the last D synchronised
  // samples all disagree with the accepted level.
  bit         s1, s2, stable, stable_prev;
  logic [3:0] sw1, sw2;
  bit         hist [D];
  logic [3:0] m_secret [2];
  logic [3:0] m_val [2];
  int         m_num [2];
  bit         m_gv [2], m_th [2], m_tl [2], m_co [2];
  bit         m_play [2], m_won [2], m_lost [2];
  int         maxg [2] = '{15, 2};

  always @(posedge clk or negedge rst_n) begin
    bit         press, all_diff;
    logic [3:0] g;
    if (!rst_n) begin
      s1 = 0; s2 = 0; stable = 0; stable_prev = 0; sw1 = '0; sw2 = '0;
      for (int i = 0; i < D; i++) hist[i] = 0;
      for (int k = 0; k < 2; k++) begin
        m_secret[k] = '0; m_val[k] = '0; m_num[k] = 0; m_gv[k] = 0;
        m_th[k] = 0; m_tl[k] = 0; m_co[k] = 0;
        m_play[k] = 0; m_won[k] = 0; m_lost[k] = 0;
      end
    end else begin
      press = stable && !stable_prev;
      g = sw2;
      for (int i = D - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = s2;
      all_diff = 1;
      for (int i = 0; i < D; i++) if (hist[i] == stable) all_diff = 0;
      stable_prev = stable;
      if (all_diff) stable = s2;
      s2 = s1; s1 = btn; sw2 = sw1; sw1 = sw;
      for (int k = 0; k < 2; k++) begin
        m_gv[k] = 0;
        if (nr) begin
          m_secret[k] = secret; m_val[k] = '0; m_num[k] = 0;
          m_th[k] = 0; m_tl[k] = 0; m_co[k] = 0;
          m_play[k] = 1; m_won[k] = 0; m_lost[k] = 0;
        end else if (press && m_play[k]) begin
          m_val[k] = g; m_num[k] = m_num[k] + 1; m_gv[k] = 1;
          m_th[k] = (g > m_secret[k]);
          m_tl[k] = (g < m_secret[k]);
          m_co[k] = (g == m_secret[k]);
          if (m_co[k]) begin
            m_play[k] = 0; m_won[k] = 1;
          end else if (m_num[k] == maxg[k]) begin
            m_play[k] = 0; m_lost[k] = 1;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic cmp(input int k, input logic [3:0] val, input logic [3:0] num,
                     input logic gv, input logic th, input logic tl,
                     input logic co, input logic ro);
    string p;
    p = (k == 0) ? "a" : "b";
    chk({p, ".SystemValAtGuess"}, int'(val), int'(m_val[k]));
    chk({p, ".GuessNum"}, int'(num), m_num[k]);
    chk({p, ".guess_valid"}, int'(gv), int'(m_gv[k]));
    chk({p, ".too_high"}, int'(th), int'(m_th[k]));
    chk({p, ".too_low"}, int'(tl), int'(m_tl[k]));
    chk({p, ".correct"}, int'(co), int'(m_co[k]));
    chk({p, ".round_over"}, int'(ro), int'(m_won[k] || m_lost[k]));
    chk({p, ".onehot_flags"}, int'((int'(th) + int'(tl) + int'(co)) <= 1), 1);
  endtask

  always @(negedge clk) begin
    cmp(0, if_a.SystemValAtGuess, if_a.GuessNum, if_a.guess_valid,
        if_a.too_high, if_a.too_low, if_a.correct, if_a.round_over);
    cmp(1, if_b.SystemValAtGuess, if_b.GuessNum, if_b.guess_valid,
        if_b.too_high, if_b.too_low, if_b.correct, if_b.round_over);
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic round(input logic [3:0] s);
    @(negedge clk); nr = 1'b1; secret = s;
    @(negedge clk); nr = 1'b0;
  endtask

  task automatic press(input int hold);
    @(negedge clk); btn = 1'b1;
    wait_n(hold);
    btn = 1'b0;
    wait_n(D + 4);
  endtask

  task automatic guess(input logic [3:0] v);
    @(negedge clk); sw = v;
    wait_n(2);
    press(D + 4);
  endtask

  task automatic bounce();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); btn = ~btn;
      @(negedge clk);
    end
  endtask

  task automatic zeros_a(input string tag);
    chk({tag, ".val"}, int'(if_a.SystemValAtGuess), 0);
    chk({tag, ".num"}, int'(if_a.GuessNum), 0);
    chk({tag, ".gv"}, int'(if_a.guess_valid), 0);
    chk({tag, ".flags"}, int'({if_a.too_high, if_a.too_low, if_a.correct}), 0);
    chk({tag, ".ro"}, int'(if_a.round_over), 0);
  endtask

  initial begin
    int act;
    wait_n(3);
    zeros_a("reset_a");
    chk("reset_b.num", int'(if_b.GuessNum), 0);
    @(negedge clk); rst_n = 1'b1;

    // Clean press: guess_valid exactly at E0+D+2.
    round(4'd9);
    @(negedge clk); sw = 4'd5;
    wait_n(2);
    btn = 1'b1;
    @(posedge clk);
    repeat (D + 1) @(posedge clk);
    #1 chk("clean.gv_early", int'(if_a.guess_valid), 0);
    @(posedge clk);
    #1 chk("clean.gv", int'(if_a.guess_valid), 1);
    chk("clean.too_low", int'(if_a.too_low), 1);
    chk("clean.num", int'(if_a.GuessNum), 1);
    chk("clean.val", int'(if_a.SystemValAtGuess), 5);
    @(posedge clk);
    #1 chk("clean.gv_once", int'(if_a.guess_valid), 0);
    wait_n(3); btn = 1'b0;
    wait_n(D + 4);

    // Bounce alone, then bounce settling high.
    bounce();
    btn = 1'b0;
    wait_n(D + 4);
    chk("bounce.num", int'(if_a.GuessNum), 1);
    bounce();
    press(D + 4);
    chk("bounce_hold.num", int'(if_a.GuessNum), 2);
    chk("bounce_hold.b_lost", int'(if_b.round_over), 1);

    // Win on a: 12, 1, 3 against secret 3.
    round(4'd3);
    guess(4'd12);
    chk("win.too_high", int'(if_a.too_high), 1);
    guess(4'd1);
    chk("win.too_low", int'(if_a.too_low), 1);
    guess(4'd3);
    chk("win.correct", int'(if_a.correct), 1);
    chk("win.num", int'(if_a.GuessNum), 3);
    chk("win.ro", int'(if_a.round_over), 1);
    guess(4'd7);
    chk("win.after_num", int'(if_a.GuessNum), 3);
    chk("win.after_val", int'(if_a.SystemValAtGuess), 3);

    // Loss on b (two guesses per round).
    round(4'd7);
    guess(4'd0);
    guess(4'd0);
    chk("loss.b_num", int'(if_b.GuessNum), 2);
    chk("loss.b_ro", int'(if_b.round_over), 1);
    guess(4'd0);
    chk("loss.b_ignored", int'(if_b.GuessNum), 2);
    chk("loss.a_num", int'(if_a.GuessNum), 3);

    // new_round coinciding with a press event.
    round(4'd8);
    for (int i = 1; i <= 4; i++) guess(4'(i));
    chk("coll.pre_num", int'(if_a.GuessNum), 4);
    @(negedge clk); btn = 1'b1;
    @(posedge clk);
    repeat (D + 1) @(posedge clk);
    @(negedge clk); nr = 1'b1; secret = 4'd2;
    @(posedge clk);
    #1 zeros_a("coll");
    @(negedge clk); nr = 1'b0;
    wait_n(3); btn = 1'b0;
    wait_n(D + 4);

    // Asynchronous reset mid-debounce with five guesses made.
    round(4'd10);
    for (int i = 1; i <= 5; i++) guess(4'(i));
    chk("areset.pre_num", int'(if_a.GuessNum), 5);
    @(negedge clk); btn = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 zeros_a("areset");
    @(negedge clk); btn = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    guess(4'd6);
    chk("idle.num", int'(if_a.GuessNum), 0);
    chk("idle.ro", int'(if_a.round_over), 0);

    // Randomised play against the model.
    for (int it = 0; it < 60; it++) begin
      act = int'($urandom_range(0, 9));
      if (act < 2) begin
        round(4'($urandom_range(0, 15)));
      end else if (act < 7) begin
        @(negedge clk); sw = 4'($urandom_range(0, 15));
        wait_n(int'($urandom_range(0, 3)));
        press(int'($urandom_range(1, 10)));
      end else begin
        bounce();
        if ($urandom_range(0, 1) == 1) wait_n(D + 3);
        btn = 1'b0;
        wait_n(D + 4);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/guess_entry.md
# guess_entry

Input-side front end of the binary guessing system: captures the player's guess from four slide switches and a submit push-button, synchronises and debounces them, counts accepted guesses, and compares each guess against the round's secret value. It drives the guess value and guess count consumed by the seven-segment display driver, plus the result flags that control game flow.

## Interface
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable cycles required to accept a button level change (10 ms at 100 MHz).
- MAX_GUESSES, 15: guesses allowed per round, range 1..15.

- clock_100Mhz  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low; low clears all state immediately.
- SecretVal  in  4  target value; captured only on new_round.
- new_round  in  1  single-cycle pulse; starts a round.
- GuessSwitches  in  4  raw, asynchronous slide switches.
- SubmitButton  in  1  raw, asynchronous, active-high, bouncing push-button.
- SystemValAtGuess  out  4  switch value latched at the last accepted guess.
- GuessNum  out  4  accepted guesses in the current round.
- guess_valid  out  1  one-cycle pulse per accepted guess.
- too_high / too_low / correct  out  1 each  result of the last accepted guess; at most one high.
- round_over  out  1  high in WON or LOST.

## Operation
- Synchroniser: SubmitButton and GuessSwitches each pass through two flops before any use.
- Debouncer: register btn_stable and counter db_cnt sized for DEBOUNCE_CYCLES-1.
  - Synced button == btn_stable: db_cnt <= 0.
  - Differs and db_cnt < DEBOUNCE_CYCLES-1: db_cnt increments.
  - Differs and db_cnt == DEBOUNCE_CYCLES-1: btn_stable <= synced button; db_cnt <= 0.
  - One cycle of agreement during bounce resets the count. The debouncer runs in every FSM state.
- Press event: btn_stable is 1 and its previous-cycle copy is 0. Releases generate no event.
- FSM states:
  - IDLE (reset state): presses ignored; new_round -> PLAY.
  - PLAY: a press is an accepted guess.
  - WON: presses ignored; new_round -> PLAY.
  - LOST: presses ignored; new_round -> PLAY.
- new_round, in any state:
  - Captures SecretVal into secret_q.
  - Clears GuessNum, SystemValAtGuess and all flags.
  - Enters PLAY.
- new_round and a press in the same cycle: new_round wins; the press is discarded with no guess_valid.
- Accepted guess, with g = synchronised GuessSwitches at that edge:
  - SystemValAtGuess <= g; GuessNum <= GuessNum+1; guess_valid pulses.
  - Comparison is unsigned 4-bit:
    - g > secret_q: too_high=1.
    - g < secret_q: too_low=1.
    - g == secret_q: correct=1 and next state WON.
  - Wrong guess when the incremented GuessNum equals MAX_GUESSES: next state LOST.
  - Correct on the last allowed guess -> WON, not LOST.
- GuessNum never exceeds MAX_GUESSES and never wraps.
- Flags and SystemValAtGuess hold until the next accepted guess or new_round.
- round_over = (state==WON or state==LOST), registered.

## Timing
- Reset values: SystemValAtGuess=0, GuessNum=0, guess_valid=0, too_high=0, too_low=0, correct=0, round_over=0, state IDLE, secret_q=0, db_cnt=0, btn_stable=0, all sync flops 0.
- Reset assertion clears outputs asynchronously, including mid-debounce and mid-round. After deassertion the block waits in IDLE.
- Button latency: call edge E0 the first rising edge to sample SubmitButton high, with the button clean afterwards. btn_stable rises at edge E0+DEBOUNCE_CYCLES+1. guess_valid, the flags, GuessNum, SystemValAtGuess and the state update at edge E0+DEBOUNCE_CYCLES+2.
- guess_valid is high for exactly one cycle.
- round_over goes high on the same edge as the final guess's flags.
- new_round takes effect on the edge that samples it.
- Switch value used is the synchronised value, i.e. GuessSwitches as of two edges earlier.

## Test plan
- Clean press, DEBOUNCE_CYCLES=4: reset, new_round with SecretVal=9, switches=5, button high from E0. Expect guess_valid only at edge E0+6, too_low=1, GuessNum=1, SystemValAtGuess=5.
- Bounce rejection: button toggles every 2 cycles for 20 cycles, then goes low. Expect no guess_valid and GuessNum unchanged. The same bounce followed by a hold high produces exactly one guess.
- Win: SecretVal=3; guesses 12, 1, 3. Expect flags too_high, too_low, then correct; GuessNum=3; round_over=1. A further press leaves all outputs unchanged.
- Loss: MAX_GUESSES=2, SecretVal=7; guesses 0, 0. Expect LOST, round_over=1, GuessNum=2. A third press is ignored.
- Collision: new_round in the same cycle as a press event while in PLAY with GuessNum=4. Expect GuessNum=0, flags cleared, no guess_valid.
- Async reset mid-debounce with GuessNum=5: assert reset between clock edges. Expect outputs zero before the next edge, and IDLE after release; a press before new_round is ignored.
